// File: rtl/paralelo_serial_tx_pkg.sv
// Shared definitions for the serial link: symbol width, the COM idle /
// alignment symbol, the transmitter/receiver state enum and the default
// number of sync symbols sent after reset.
package paralelo_serial_tx_pkg;

  localparam int SYMBOL_BITS = 8;
  localparam logic [SYMBOL_BITS-1:0] COM_SYMBOL = 8'hBC;
  localparam int DEFAULT_SYNC_COUNT = 4;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } tx_state_e;

endpackage

// File: rtl/paralelo_serial_tx.sv
// Byte-to-bitstream serializer, MSB first, one bit per clk_32f cycle.
// After reset it emits SYNC_COUNT COM symbols so the receiver can lock,
// then accepts bytes through a ready/valid handshake; empty slots carry COM.
//
// Ports:
//   clk_32f   - bit clock
//   reset     - synchronous, active-high
//   data_in   - byte to transmit
//   valid_in  - data_in holds a valid byte
//   ready_out - one-cycle pulse in the last bit of each slot that may take
//               a byte; byte accepted on valid_in && ready_out
//   data_out  - registered serial bitstream
//   tx_active - current symbol in the shift slot is data, not COM
//               (leads data_out by one cycle)
module paralelo_serial_tx #(
  parameter int SYNC_COUNT = paralelo_serial_tx_pkg::DEFAULT_SYNC_COUNT,
  parameter logic [paralelo_serial_tx_pkg::SYMBOL_BITS-1:0] COM_SYMBOL =
    paralelo_serial_tx_pkg::COM_SYMBOL
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       tx_active
);

  import paralelo_serial_tx_pkg::*;

  localparam int BW = $clog2(SYMBOL_BITS);
  localparam int SW = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(SYMBOL_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_COUNT - 1);
  localparam logic [SW-1:0] SYNC_ONE  = SW'(1);

  tx_state_e              state, state_nxt;
  logic [BW-1:0]          bit_cnt;
  logic [SW-1:0]          sync_cnt, sync_cnt_nxt;
  logic [SYMBOL_BITS-1:0] cur_sym, cur_sym_nxt;
  logic                   sym_is_data, sym_is_data_nxt;
  logic                   boundary;

  assign boundary  = (bit_cnt == LAST_BIT);
  // The last sync slot already behaves like ACTIVE so the first data byte
  // can follow the final COM with no gap.
  assign ready_out = boundary && (state == ACTIVE || sync_cnt == SYNC_LAST);
  assign tx_active = sym_is_data;

  always_comb begin
    state_nxt       = state;
    sync_cnt_nxt    = sync_cnt;
    cur_sym_nxt     = cur_sym;
    sym_is_data_nxt = sym_is_data;
    if (boundary) begin
      if (ready_out) begin
        state_nxt = ACTIVE;
        if (valid_in) begin
          cur_sym_nxt     = data_in;
          sym_is_data_nxt = 1'b1;
        end else begin
          cur_sym_nxt     = COM_SYMBOL;
          sym_is_data_nxt = 1'b0;
        end
      end else begin
        sync_cnt_nxt    = sync_cnt + SYNC_ONE;
        cur_sym_nxt     = COM_SYMBOL;
        sym_is_data_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state       <= SYNC;
      bit_cnt     <= '0;
      sync_cnt    <= '0;
      cur_sym     <= COM_SYMBOL;
      sym_is_data <= 1'b0;
      data_out    <= 1'b0;
    end else begin
      state       <= state_nxt;
      sync_cnt    <= sync_cnt_nxt;
      cur_sym     <= cur_sym_nxt;
      sym_is_data <= sym_is_data_nxt;
      bit_cnt     <= bit_cnt + BIT_ONE;
      // MSB first: bit_cnt 0 selects bit 7.
      data_out    <= cur_sym[LAST_BIT - bit_cnt];
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx: a SYNC_COUNT=4 instance (a)
// and a SYNC_COUNT=1 instance (b), both compared every cycle against a
// slot-arithmetic reference model, plus literal checks for the directed
// sequences.
module tb_paralelo_serial_tx;
  import paralelo_serial_tx_pkg::*;

  logic clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  logic       rst_a, vld_a, rdy_a, do_a, act_a;
  logic [7:0] din_a;
  logic       rst_b, vld_b, rdy_b, do_b, act_b;
  logic [7:0] din_b;

  paralelo_serial_tx #(.SYNC_COUNT(4)) dut_a (
    .clk_32f(clk_32f), .reset(rst_a), .data_in(din_a), .valid_in(vld_a),
    .ready_out(rdy_a), .data_out(do_a), .tx_active(act_a));

  paralelo_serial_tx #(.SYNC_COUNT(1)) dut_b (
    .clk_32f(clk_32f), .reset(rst_b), .data_in(din_b), .valid_in(vld_b),
    .ready_out(rdy_b), .data_out(do_b), .tx_active(act_b));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: m_e counts edges since reset; slot s spans edges
  // 8s+1..8s+8 on data_out and is chosen at edge 8s (slot 0 is COM).
  int         m_e   [2];
  logic [7:0] m_sym [2];
  logic       m_isd [2];
  logic       x_do  [2];
  logic       x_rdy [2];
  logic       x_act [2];

  logic [31:0] sh_a;
  logic [15:0] sh_b;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       xdo;
    logic       xrdy;
    logic       xact;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  task automatic model_step(input int k, input logic r, input logic v,
                            input logic [7:0] d, input int sc);
    logic [7:0] s;
    int idx;
    if (r) begin
      m_e[k] = 0; m_sym[k] = COM_SYMBOL; m_isd[k] = 1'b0; x_do[k] = 1'b0;
    end else begin
      m_e[k]++;
      s = m_sym[k];
      idx = 7 - ((m_e[k] - 1) % 8);
      x_do[k] = s[idx];
      if (m_e[k] % 8 == 0) begin
        if (m_e[k] / 8 >= sc && v) begin
          m_sym[k] = d; m_isd[k] = 1'b1;
        end else begin
          m_sym[k] = COM_SYMBOL; m_isd[k] = 1'b0;
        end
      end
    end
    x_rdy[k] = (m_e[k] % 8 == 7) && ((m_e[k] + 1) / 8 >= sc);
    x_act[k] = m_isd[k];
  endtask

  task automatic tick();
    @(posedge clk_32f);
    model_step(0, rst_a, vld_a, din_a, 4);
    model_step(1, rst_b, vld_b, din_b, 1);
    #1;
    cyc++;
    chk("a_data_out",  do_a,  x_do[0]);
    chk("a_ready_out", rdy_a, x_rdy[0]);
    chk("a_tx_active", act_a, x_act[0]);
    chk("b_data_out",  do_b,  x_do[1]);
    chk("b_ready_out", rdy_b, x_rdy[1]);
    chk("b_tx_active", act_b, x_act[1]);
    sh_a = {sh_a[30:0], do_a};
    sh_b = {sh_b[14:0], do_b};
  endtask

  task automatic wait_rdy_a();
    for (int i = 0; i < 40 && !rdy_a; i++) tick();
    chk("a_ready_timeout", rdy_a, 1);
  endtask

  initial begin
    int early;
    int rcount;
    // edges 31..41 after reset release with 0xA5 held valid
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1};

    sh_a = '0; sh_b = '0;
    rst_a = 1'b1; vld_a = 1'b0; din_a = 8'h00;
    rst_b = 1'b1; vld_b = 1'b0; din_b = 8'h00;
    repeat (3) tick();
    chk("a_reset_outs", {do_a, rdy_a, act_a}, 0);
    chk("b_reset_outs", {do_b, rdy_b, act_b}, 0);

    // SYNC_COUNT=1: one COM then 0xC3 accepted at edge 8; a stays in reset
    rst_b = 1'b0; vld_b = 1'b1; din_b = 8'hC3;
    early = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i < 7 && rdy_b) early++;
      if (i == 7) chk("b_first_ready", rdy_b, 1);
    end
    chk("b_ready_early", early, 0);
    chk("b_com_then_c3", sh_b, 16'hBCC3);
    chk("a_held_reset", {do_a, rdy_a, act_a}, 0);
    vld_b = 1'b0;

    // idle after reset: COM stream, ready first after edge 31
    rst_a = 1'b0; vld_a = 1'b0;
    early = 0;
    for (int i = 1; i <= 48; i++) begin
      tick();
      if (i < 31 && rdy_a) early++;
      if (i == 31 || i == 39 || i == 47) chk("t1_ready_pulse", rdy_a, 1);
      if (i == 32) chk("t1_com_stream", sh_a, 32'hBCBCBCBC);
      chk("t1_idle_active", act_a, 0);
    end
    chk("t1_ready_early", early, 0);

    // 0xA5 held valid from reset: accepted at edge 32
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    vld_a = 1'b1; din_a = 8'hA5;
    repeat (30) tick();
    for (int i = 0; i < 11; i++) begin
      vld_a = tbl[i].v; din_a = tbl[i].d;
      tick();
      chk("t2_data_out",  do_a,  tbl[i].xdo);
      chk("t2_ready_out", rdy_a, tbl[i].xrdy);
      chk("t2_tx_active", act_a, tbl[i].xact);
    end
    vld_a = 1'b0;

    // back-to-back 0x00, 0xFF on their ready pulses
    wait_rdy_a();
    vld_a = 1'b1; din_a = 8'h00;
    tick();
    vld_a = 1'b0;
    rcount = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (rdy_a && i <= 8) begin
        rcount++; vld_a = 1'b1; din_a = 8'hFF;
      end else begin
        vld_a = 1'b0;
      end
    end
    chk("t3_ready_pulses", rcount, 1);
    chk("t3_stream", sh_a[15:0], 16'h00FF);

    // gap slot gets COM; mid-symbol valid/data changes only affect next slot
    repeat (3) tick();
    chk("t4_gap_active", act_a, 0);
    vld_a = 1'b1; din_a = 8'h3C;
    repeat (2) tick();
    din_a = 8'h99;
    repeat (3) tick();
    vld_a = 1'b0;
    tick();
    chk("t4_data_active", act_a, 1);
    repeat (7) tick();
    chk("t4_gap_then_99", sh_a[15:0], 16'hBC99);

    // reset in the middle of 0x5A drops it and restarts sync
    wait_rdy_a();
    vld_a = 1'b1; din_a = 8'h5A;
    tick();
    vld_a = 1'b0;
    repeat (4) tick();
    rst_a = 1'b1;
    tick();
    chk("t5_reset_data_out", do_a, 0);
    rst_a = 1'b0;
    early = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i < 31 && rdy_a) early++;
      if (i == 31) chk("t5_ready_after_sync", rdy_a, 1);
    end
    chk("t5_ready_early", early, 0);
    chk("t5_four_com", sh_a, 32'hBCBCBCBC);

    // randomized traffic with occasional resets on both instances
    for (int i = 0; i < 1500; i++) begin
      rst_a = ($urandom_range(0, 99) == 0);
      rst_b = ($urandom_range(0, 99) == 0);
      vld_a = 1'($urandom_range(0, 1));
      vld_b = 1'($urandom_range(0, 1));
      din_a = 8'($urandom);
      din_b = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
